nvdla_csb_seq: RTL and testbench

Parametrised CSB command sequencer for the NVDLA HWPE wrapper. It replaces single-shot register access control with a queued engine: software pushes up to DEPTH read, write and wait-for-interrupt commands, then pulses start. The block issues them in order to the CSB engine, returns read data on a stream port, and raises done when the queue drains. It sits between the HWPE slave/regfile and the CSB engine. Read results feed the streamer sink.

---
 rtl/nvdla_csb_seq.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_nvdla_csb_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_csb_seq.sv
`default_nettype none
// ============================================================================
// Module   : nvdla_csb_seq
// Purpose  : Queued CSB command sequencer. Software pushes up to DEPTH
//            read / write / wait-for-interrupt commands, then pulses start.
//            Commands are issued in order to the CSB engine. Read results
//            are returned on a valid/ready stream. done_o pulses when the
//            queue drains.
// Revision : 1.0 - initial release
//
// Build option:
//   NVDLA_CSB_SEQ_TIMEOUT_EN - when defined, wait_intr commands carry a
//   timeout counter. A timeout sets err_o and the command completes.
//   When undefined, wait_intr waits indefinitely for intr_i.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   clear_i                     synchronous flush of queue, FSM and err_o
//   cmd_valid_i/cmd_ready_o     command push handshake
//   cmd_op_i/addr_i/wdat_i      command payload (00 rd, 01 wr, 10 wait, 11 rsvd)
//   start_i                     begin execution from IDLE
//   csb_req_valid_o/ready_i     CSB request handshake
//   csb_addr_o/wdat_o/write_o   CSB request payload (zero while not valid)
//   csb_rvalid_i/rdata_i        CSB read response
//   csb_wr_complete_i           CSB write completion
//   intr_i                      NVDLA interrupt level
//   timeout_cycles_i            wait_intr timeout, 0 disables
//   rd_valid_o/ready_i/data_o   read-result stream
//   busy_o, done_o, err_o       status
//   count_o                     queue occupancy
// ============================================================================
module nvdla_csb_seq #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 32,
  parameter int unsigned TO_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [1:0]                   cmd_op_i,
  input  logic [AW-1:0]                cmd_addr_i,
  input  logic [DW-1:0]                cmd_wdat_i,
  input  logic                         start_i,
  output logic                         csb_req_valid_o,
  input  logic                         csb_req_ready_i,
  output logic [AW-1:0]                csb_addr_o,
  output logic [DW-1:0]                csb_wdat_o,
  output logic                         csb_write_o,
  input  logic                         csb_rvalid_i,
  input  logic [DW-1:0]                csb_rdata_i,
  input  logic                         csb_wr_complete_i,
  input  logic                         intr_i,
  input  logic [TO_W-1:0]              timeout_cycles_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [DW-1:0]                rd_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_RSP  = 3'd2,
    S_PUSH_RD   = 3'd3,
    S_WAIT_INTR = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t          state_q, state_d;

  // Command queue storage (payload only; no reset needed)
  logic [1:0]      op_mem   [DEPTH];
  logic [AW-1:0]   addr_mem [DEPTH];
  logic [DW-1:0]   wdat_mem [DEPTH];

  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            err_q;
  logic [DW-1:0]   rd_data_q;

  logic            push, pop;
  logic            err_set;
  logic            capture_rd;
  logic            req_valid;
  logic            rd_valid;
  logic            done;
  logic            wait_entry;
  logic            timeout_hit;

  logic [1:0]      head_op;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_wdat;

  assign head_op   = op_mem[rd_ptr_q];
  assign head_addr = addr_mem[rd_ptr_q];
  assign head_wdat = wdat_mem[rd_ptr_q];

  // No same-cycle bypass: readiness depends only on registered occupancy.
  // clear_i suppresses a push in the same cycle.
  assign cmd_ready_o = (count_q < DEPTH_C);
  assign push        = cmd_valid_i & cmd_ready_o & ~clear_i;

  // --------------------------------------------------------------------------
  // Queue write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (push) begin
      op_mem[wr_ptr_q]   <= cmd_op_i;
      addr_mem[wr_ptr_q] <= cmd_addr_i;
      wdat_mem[wr_ptr_q] <= cmd_wdat_i;
    end
  end

  // --------------------------------------------------------------------------
  // Queue pointers and occupancy; DEPTH is a power of two so pointers wrap
  // naturally at their width.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional wait_intr timeout counter
  // --------------------------------------------------------------------------
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else if (clear_i || wait_entry) begin
      to_cnt_q <= '0;
    end else if (state_q == S_WAIT_INTR) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout_hit = (timeout_cycles_i != '0) && (to_cnt_q == timeout_cycles_i);
`else
  logic [TO_W:0] unused_timeout;
  assign unused_timeout = {timeout_cycles_i, wait_entry};
  assign timeout_hit    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else if (clear_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    err_set    = 1'b0;
    capture_rd = 1'b0;
    req_valid  = 1'b0;
    rd_valid   = 1'b0;
    done       = 1'b0;
    wait_entry = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (count_q != '0) ? S_ISSUE : S_DONE;
        end
      end

      S_ISSUE: begin
        case (head_op)
          OP_RD, OP_WR: begin
            req_valid = 1'b1;
            if (csb_req_ready_i) state_d = S_WAIT_RSP;
          end
          OP_WAIT: begin
            wait_entry = 1'b1;
            state_d    = S_WAIT_INTR;
          end
          default: begin
            // Reserved opcode: flag it, drop it, keep the sequence going.
            err_set = 1'b1;
            pop     = 1'b1;
            state_d = S_NEXT;
          end
        endcase
      end

      S_WAIT_RSP: begin
        // The head stays in the queue until its response arrives, so its
        // opcode selects which completion pulse ends the wait.
        if (head_op == OP_WR) begin
          if (csb_wr_complete_i) begin
            pop     = 1'b1;
            state_d = S_NEXT;
          end
        end else if (csb_rvalid_i) begin
          pop        = 1'b1;
          capture_rd = 1'b1;
          state_d    = S_PUSH_RD;
        end
      end

      S_PUSH_RD: begin
        rd_valid = 1'b1;
        if (rd_ready_i) state_d = S_NEXT;
      end

      S_WAIT_INTR: begin
        // intr_i takes priority over a coincident timeout.
        if (intr_i) begin
          pop     = 1'b1;
          state_d = S_NEXT;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          pop     = 1'b1;
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        state_d = (count_q != '0) ? S_ISSUE : S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sticky error and captured read data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (clear_i) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  // Only written on a read response, so it is stable throughout PUSH_RD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (capture_rd && !clear_i) begin
      rd_data_q <= csb_rdata_i;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Request payload is forced to zero while no request is offered,
  // which keeps the queue storage (unreset) off the port after reset.
  // --------------------------------------------------------------------------
  assign csb_req_valid_o = req_valid;
  assign csb_addr_o      = req_valid ? head_addr : '0;
  assign csb_wdat_o      = req_valid ? head_wdat : '0;
  assign csb_write_o     = req_valid & (head_op == OP_WR);

  assign rd_valid_o = rd_valid;
  assign rd_data_o  = rd_data_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done;
  assign err_o      = err_q;
  assign count_o    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_nvdla_csb_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nvdla_csb_seq
// Purpose  : Directed self-checking bench for nvdla_csb_seq. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nvdla_csb_seq;

  localparam int DEPTH = 8;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int TO_W  = 16;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [AW-1:0]     cmd_addr = '0;
  logic [DW-1:0]     cmd_wdat = '0;
  logic              start = 1'b0;
  logic              csb_req_valid;
  logic              csb_req_ready = 1'b0;
  logic [AW-1:0]     csb_addr;
  logic [DW-1:0]     csb_wdat;
  logic              csb_write;
  logic              csb_rvalid = 1'b0;
  logic [DW-1:0]     csb_rdata = '0;
  logic              csb_wr_complete = 1'b0;
  logic              intr = 1'b0;
  logic [TO_W-1:0]   timeout_cycles = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DW-1:0]     rd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [$clog2(DEPTH+1)-1:0] count;

  int errors = 0;
  int checks = 0;

  nvdla_csb_seq #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .TO_W  (TO_W)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .clear_i           (clear),
    .cmd_valid_i       (cmd_valid),
    .cmd_ready_o       (cmd_ready),
    .cmd_op_i          (cmd_op),
    .cmd_addr_i        (cmd_addr),
    .cmd_wdat_i        (cmd_wdat),
    .start_i           (start),
    .csb_req_valid_o   (csb_req_valid),
    .csb_req_ready_i   (csb_req_ready),
    .csb_addr_o        (csb_addr),
    .csb_wdat_o        (csb_wdat),
    .csb_write_o       (csb_write),
    .csb_rvalid_i      (csb_rvalid),
    .csb_rdata_i       (csb_rdata),
    .csb_wr_complete_i (csb_wr_complete),
    .intr_i            (intr),
    .timeout_cycles_i  (timeout_cycles),
    .rd_valid_o        (rd_valid),
    .rd_ready_i        (rd_ready),
    .rd_data_o         (rd_data),
    .busy_o            (busy),
    .done_o            (done),
    .err_o             (err),
    .count_o           (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdat);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdat  = wdat;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (csb_req_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 64'(csb_req_valid), 64'd1);
  endtask

  // Accept a write request, then complete it one cycle later.
  // Returns on the falling edge of the cycle after the completion pulse.
  task automatic serve_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wait_req();
    check("wr_addr", 64'(csb_addr), 64'(addr));
    check("wr_data", 64'(csb_wdat), 64'(data));
    check("wr_flag", 64'(csb_write), 64'd1);
    csb_req_ready = 1'b1;
    @(negedge clk);
    csb_req_ready = 1'b0;
    check("wr_rsp_no_req", 64'(csb_req_valid), 64'd0);
    csb_wr_complete = 1'b1;
    @(negedge clk);
    csb_wr_complete = 1'b0;
  endtask

  // Accept a read request and return data; ends where rd_valid must be high.
  task automatic serve_read(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wait_req();
    check("rd_addr", 64'(csb_addr), 64'(addr));
    check("rd_flag", 64'(csb_write), 64'd0);
    csb_req_ready = 1'b1;
    @(negedge clk);
    csb_req_ready = 1'b0;
    csb_rvalid = 1'b1;
    csb_rdata  = data;
    @(negedge clk);
    csb_rvalid = 1'b0;
    csb_rdata  = 32'hBAD0BAD0;
    check("rd_valid_rise", 64'(rd_valid), 64'd1);
    check("rd_data", 64'(rd_data), 64'(data));
  endtask

  task automatic watch(input int n, output int dn, output int rq, output int rv);
    dn = 0;
    rq = 0;
    rv = 0;
    for (int i = 0; i < n; i++) begin
      if (done === 1'b1) dn++;
      if (csb_req_valid === 1'b1) rq++;
      if (rd_valid === 1'b1) rv++;
      @(negedge clk);
    end
  endtask

  task automatic expect_done(input string tag);
    int dn, rq, rv;
    watch(5, dn, rq, rv);
    check({tag, "_done_pulses"}, 64'(dn), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, rq, rv, n;
    logic stable;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_req_valid", 64'(csb_req_valid), 64'd0);
    check("rst_addr", 64'(csb_addr), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(count), 64'd0);

    // ---------------- write then read ----------------
    push(OP_WR, 16'h0010, 32'hDEADBEEF);
    push(OP_RD, 16'h0014, 32'h0);
    check("t1_count", 64'(count), 64'd2);
    pulse_start();
    check("t1_req_latency", 64'(csb_req_valid), 64'd1);
    serve_write(16'h0010, 32'hDEADBEEF);
    check("t1_next_no_req", 64'(csb_req_valid), 64'd0);
    @(negedge clk);
    check("t1_req_c_plus_2", 64'(csb_req_valid), 64'd1);
    serve_read(16'h0014, 32'h12345678);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check("t1_rd_valid_drop", 64'(rd_valid), 64'd0);
    expect_done("t1");

    // ---------------- fill queue, 9th push held off ----------------
    for (int i = 0; i < 8; i++) push(OP_WR, 16'h0100 + 16'(4 * i), 32'hC000_0000 + 32'(i));
    check("t2_full_count", 64'(count), 64'd8);
    check("t2_full_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1;
    cmd_op    = OP_WR;
    cmd_addr  = 16'h0200;
    cmd_wdat  = 32'h0000_0099;
    repeat (3) @(negedge clk);
    check("t2_held_count", 64'(count), 64'd8);
    pulse_start();
    serve_write(16'h0100, 32'hC000_0000);
    check("t2_after_pop_count", 64'(count), 64'd7);
    check("t2_after_pop_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t2_ninth_accepted", 64'(count), 64'd8);
    for (int i = 1; i < 8; i++) serve_write(16'h0100 + 16'(4 * i), 32'hC000_0000 + 32'(i));
    serve_write(16'h0200, 32'h0000_0099);
    expect_done("t2");

    // ---------------- read result back-pressure ----------------
    push(OP_RD, 16'h0020, 32'h0);
    push(OP_WR, 16'h0024, 32'hA5A5A5A5);
    pulse_start();
    serve_read(16'h0020, 32'h0BADCAFE);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rd_valid !== 1'b1 || rd_data !== 32'h0BADCAFE || csb_req_valid !== 1'b0) stable = 1'b0;
    end
    check("t3_hold_stable", 64'(stable), 64'd1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    serve_write(16'h0024, 32'hA5A5A5A5);
    expect_done("t3");

    // ---------------- wait_intr satisfied by interrupt ----------------
    timeout_cycles = '0;
    push(OP_WAIT, 16'h0, 32'h0);
    pulse_start();
    repeat (3) @(negedge clk);
    check("t4_waiting_busy", 64'(busy), 64'd1);
    intr = 1'b1;
    @(negedge clk);
    intr = 1'b0;
    expect_done("t4");
    check("t4_no_err", 64'(err), 64'd0);

    // ---------------- wait_intr with timeout 5, no interrupt ----------------
    timeout_cycles = 16'd5;
    push(OP_WAIT, 16'h0, 32'h0);
    push(OP_WR, 16'h0030, 32'h30303030);
    pulse_start();
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
    check("t5_timeout_err", 64'(err), 64'd1);
    check("t5_timeout_cycles", 64'(n), 64'd7);
    serve_write(16'h0030, 32'h30303030);
    expect_done("t5");
    check("t5_err_sticky", 64'(err), 64'd1);
`else
    repeat (60) @(negedge clk);
    check("t5_no_err", 64'(err), 64'd0);
    check("t5_still_busy", 64'(busy), 64'd1);
    check("t5_no_req", 64'(csb_req_valid), 64'd0);
    check("t5_count", 64'(count), 64'd2);
    intr = 1'b1;
    @(negedge clk);
    intr = 1'b0;
    serve_write(16'h0030, 32'h30303030);
    expect_done("t5");
`endif
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t5_err_cleared", 64'(err), 64'd0);
    timeout_cycles = '0;

    // ---------------- reserved op between two writes ----------------
    push(OP_WR, 16'h0040, 32'h0000_0001);
    push(OP_RSVD, 16'h0044, 32'h0000_0000);
    push(OP_WR, 16'h0048, 32'h0000_0002);
    pulse_start();
    serve_write(16'h0040, 32'h0000_0001);
    serve_write(16'h0048, 32'h0000_0002);
    check("t6_rsvd_err", 64'(err), 64'd1);
    expect_done("t6");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // ---------------- clear during WAIT_RSP (with a coincident push) ----------------
    push(OP_RD, 16'h0050, 32'h0);
    pulse_start();
    wait_req();
    csb_req_ready = 1'b1;
    @(negedge clk);
    csb_req_ready = 1'b0;
    check("t7_busy_before_clear", 64'(busy), 64'd1);
    clear     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_WR;
    cmd_addr  = 16'h0054;
    cmd_wdat  = 32'h5454_5454;
    @(negedge clk);
    clear     = 1'b0;
    cmd_valid = 1'b0;
    check("t7_idle", 64'(busy), 64'd0);
    check("t7_count", 64'(count), 64'd0);
    csb_rvalid = 1'b1;
    csb_rdata  = 32'hFEEDFACE;
    @(negedge clk);
    csb_rvalid = 1'b0;
    watch(6, dn, rq, rv);
    check("t7_no_rd_valid", 64'(rv), 64'd0);
    check("t7_no_done", 64'(dn), 64'd0);
    check("t7_still_idle", 64'(busy), 64'd0);

    // ---------------- start with empty queue ----------------
    check("t8_empty", 64'(count), 64'd0);
    pulse_start();
    watch(4, dn, rq, rv);
    check("t8_done_pulses", 64'(dn), 64'd1);
    check("t8_no_req", 64'(rq), 64'd0);
    check("t8_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
